// File: rtl/button_step_if.sv
// button_step_if: button inputs and step-pulse outputs of the oven timer front end
interface button_step_if;
  logic button1, button2, toggle_set, inc_pulse, dec_pulse, held;
  modport master(output button1, button2, toggle_set, input inc_pulse, dec_pulse, held);
  modport slave(input button1, button2, toggle_set, output inc_pulse, dec_pulse, held);
endinterface

// File: rtl/button_step_gen.sv
// button_step_gen: debounced active-low buttons to one-cycle step pulses with auto-repeat.
// ACCEL_EN: after 8 repeat pulses the repeat interval halves.
module button_step_gen #(
  parameter int DEBOUNCE_CYC  = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CNT_W         = 31
) (
  input logic clk,
  input logic rst,
  button_step_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FIRST, DELAY, REPEAT, LOCKOUT} state_t;
  state_t state;
  logic [1:0] s1, s2, db;
  logic [CNT_W-1:0] dcnt [2];
  logic [CNT_W-1:0] rcnt, period_m1;
  logic dir, p1, p2, rel, rep_hit;
  assign p1 = !db[0];
  assign p2 = !db[1];
  assign rel = dir ? db[0] : db[1];
  assign rep_hit = (state == DELAY) ? rcnt == CNT_W'(REPEAT_DELAY - 1)
                                    : (state == REPEAT && rcnt == period_m1);
`ifdef ACCEL_EN
  logic [3:0] acnt;
  assign period_m1 = (acnt >= 4'd8) ? CNT_W'(REPEAT_PERIOD / 2 - 1) : CNT_W'(REPEAT_PERIOD - 1);
  always_ff @(posedge clk)
    acnt <= (rst || !(state == DELAY || state == REPEAT)) ? '0
          : (rep_hit && !rel && !bus.toggle_set && acnt != 4'hf) ? acnt + 1'b1 : acnt;
`else
  assign period_m1 = CNT_W'(REPEAT_PERIOD - 1);
`endif
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
    end else begin
      s1 <= {bus.button2, bus.button1};
      s2 <= s1;
    end
  // counter tracks consecutive cycles the synchronised level disagrees with the debounced one
  always_ff @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (rst) begin
        dcnt[i] <= '0;
        db[i]   <= 1'b1;
      end else if (s2[i] == db[i]) dcnt[i] <= '0;
      else if (dcnt[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
        db[i]   <= s2[i];
        dcnt[i] <= '0;
      end else dcnt[i] <= dcnt[i] + 1'b1;
  always_ff @(posedge clk)
    if (rst) begin
      state         <= IDLE;
      dir           <= 1'b0;
      rcnt          <= '0;
      bus.inc_pulse <= 1'b0;
      bus.dec_pulse <= 1'b0;
      bus.held      <= 1'b0;
    end else begin
      bus.inc_pulse <= 1'b0;
      bus.dec_pulse <= 1'b0;
      if (state != IDLE && bus.toggle_set) begin
        state    <= LOCKOUT;
        bus.held <= 1'b1;
      end else
        case (state)
          IDLE: if (!bus.toggle_set && (p1 || p2)) begin
            state         <= FIRST;
            dir           <= p1;
            rcnt          <= '0;
            bus.inc_pulse <= p1;
            bus.dec_pulse <= !p1;
            bus.held      <= 1'b1;
          end
          FIRST: begin
            state <= DELAY;
            rcnt  <= rcnt + 1'b1;
          end
          DELAY, REPEAT: if (rel) begin
            state    <= IDLE;
            bus.held <= 1'b0;
          end else if (rep_hit) begin
            state         <= REPEAT;
            rcnt          <= '0;
            bus.inc_pulse <= dir;
            bus.dec_pulse <= !dir;
          end else rcnt <= rcnt + 1'b1;
          LOCKOUT: if (!bus.toggle_set && !p1 && !p2) begin
            state    <= IDLE;
            bus.held <= 1'b0;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
